// File: rtl/function_unit_pkg.sv
// Shared types for the registered function unit: function-select encodings,
// flag bit positions and FSM states.
package function_unit_pkg;

  typedef enum logic [3:0] {
    FS_ADD  = 4'b0000,
    FS_SUB  = 4'b0001,
    FS_SLL  = 4'b0010,
    FS_MUL  = 4'b0011,
    FS_SLT  = 4'b0100,
    FS_SLTU = 4'b0110,
    FS_XOR  = 4'b1000,
    FS_SRL  = 4'b1010,
    FS_SRA  = 4'b1011,
    FS_OR   = 4'b1100,
    FS_AND  = 4'b1110
  } fs_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic [3:0] make_flags(input logic z, input logic c,
                                            input logic n, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks
// per operation. Only built when FUNCTION_UNIT_MUL_EN is defined.
`ifdef FUNCTION_UNIT_MUL_EN
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The final iteration's sum is presented directly so the result registers
  // on the same edge that retires the last partial product.
  assign product  = acc_next;
  assign done     = (count == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(WIDTH);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // NOTE: the datapath registers carry no reset; they are only observed while
  // count is non-zero, and count itself is reset.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule
`endif

// File: rtl/function_unit_seq.sv
// Registered, valid/ready function unit: ALU, compare, shift and, when
// FUNCTION_UNIT_MUL_EN is defined, a WIDTH-cycle iterative multiply.
module function_unit_seq
  import function_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       zcnv_flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  logic             accept;
  logic             idle;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [3:0]       mul_flags;

  assign shamt    = b[SHW-1:0];
  assign add_full = {1'b0, a} + {1'b0, b};
  // a + ~b + 1: the carry-out is the "no borrow" indication for SUB.
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fs)
      FS_ADD: begin
        alu_res = add_full[MSB:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      FS_SUB: begin
        alu_res = sub_full[MSB:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      FS_SLL:  alu_res = a << shamt;
      FS_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      FS_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      FS_XOR:  alu_res = a ^ b;
      FS_SRL:  alu_res = a >> shamt;
      FS_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      FS_OR:   alu_res = a | b;
      FS_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = make_flags(alu_res == '0, alu_c, alu_res[MSB], alu_v);
  assign mul_flags = make_flags(mul_product == '0, 1'b0, mul_product[MSB], 1'b0);

  assign in_ready = !rst && idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef FUNCTION_UNIT_MUL_EN
  state_e state_q;
  state_e state_d;

  assign mul_start = accept && (fs == FS_MUL);
  assign idle      = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_start   = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign idle        = 1'b1;
  assign busy        = 1'b0;
`endif

  // A MUL accept clears out_valid: any previous result was transferred on
  // that same edge, and the product arrives later via mul_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      zcnv_flags <= '0;
    end else if (accept && !mul_start) begin
      out_valid  <= 1'b1;
      result     <= alu_res;
      zcnv_flags <= alu_flags;
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      result     <= mul_product;
      zcnv_flags <= mul_flags;
    end else if (accept || (out_valid && out_ready)) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/function_unit_seq.md
# function_unit_seq

Registered, handshaked successor of the combinational function unit, parametrised in datapath width. It executes the same RISC-style ALU and shift operation set, plus an optional iterative multiply, behind a valid/ready input and output interface. Single-cycle operations have one-cycle latency and full throughput. It sits between the operand-fetch stage and writeback, and stalls upstream while a multi-cycle operation is in flight or the output is back-pressured.

## Interface
- `WIDTH`, default 32: datapath width. Must be at least 8 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: number of shift-amount bits taken from `b`. Derived; not overridden.
- `clk` input, 1 bit: clock. One clock domain only.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: operands and function select are valid.
- `in_ready` output, 1 bit: the unit can accept an operation this cycle.
- `a` input, `WIDTH` bits: operand A.
- `b` input, `WIDTH` bits: operand B. For shifts, `b[SHW-1:0]` is the shift amount.
- `fs` input, 4 bits: function select.
- `out_valid` output, 1 bit: `result` and `zcnv_flags` hold a completed operation.
- `out_ready` input, 1 bit: the consumer accepts the output.
- `result` output, `WIDTH` bits: operation result.
- `zcnv_flags` output, 4 bits: flags as {Z, C, N, V}.
- `busy` output, 1 bit: a multi-cycle operation is in progress.

## Operation
- **Function encodings:**
  - ADD 0000, SUB 0001, SLL 0010, MUL 0011, SLT 0100, SLTU 0110.
  - XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
  - Any other code is illegal: result 0, completes in one cycle, no error signalled.
- **Comparisons:** SLT gives 1 if a < b as signed values, else 0. SLTU gives 1 if a < b as unsigned values, else 0. Both are zero-extended to `WIDTH`.
- **Shifts:** SLL and SRL are logical. SRA replicates the sign bit. Shift amount is `b[SHW-1:0]`; the upper bits of `b` are ignored.
- **MUL:** returns the low `WIDTH` bits of the unsigned product. Signed and unsigned operands give the same low half.
- **Flags:**
  - Z = (result == 0), for all operations.
  - N = result[WIDTH-1], for all operations.
  - C: ADD gives carry-out. SUB gives 1 when there is no borrow (a >= b unsigned). All other operations give 0.
  - V: signed overflow for ADD and SUB. All other operations give 0.
- **FSM states:**
  - IDLE → MUL on accepting a MUL.
  - MUL → IDLE after `WIDTH` iterations.
  - Single-cycle operations never leave IDLE.
- **Handshake:**
  - An operation is accepted on an edge where `in_valid && in_ready`.
  - `in_ready = !rst && state==IDLE && (!out_valid || out_ready)`.
  - Output transfer occurs on an edge where `out_valid && out_ready`.
  - `result` and `zcnv_flags` stay stable while `out_valid && !out_ready`.
- **Simultaneous transfer:** an output transfer and a new acceptance on the same edge replace the output register with the new single-cycle result, and `out_valid` stays 1.
- **`busy`:** `busy = (state==MUL)`.

## Timing
- **Reset:** `out_valid`=0, `result`=0, `zcnv_flags`=0, `busy`=0, state=IDLE. `in_ready` is 0 while `rst` is high.
- **Single-cycle latency:** an operation accepted at edge t gives `out_valid`=1 after edge t. Back-to-back throughput is 1 operation per cycle when `out_ready` is held high.
- **MUL latency:**
  - The accept edge t latches the operands and loads the iteration counter.
  - One shift-add iteration runs per edge.
  - `out_valid` rises after edge t+`WIDTH`.
  - `in_ready` is 0 from t+1 until the result has been transferred.
- **Back-pressure:** with `out_valid`=1 and `out_ready`=0, nothing is accepted. This applies even in IDLE.
- **Reset mid-operation:** `rst` during the MUL state aborts the operation. No result is produced, and the block is in IDLE on the next cycle.
- **Unconsumed MUL result:** a MUL whose result is still unconsumed holds the block in IDLE with `in_ready`=0.

## Configuration
- **Macro:** `FUNCTION_UNIT_MUL_EN`.
- **Defined:** MUL (0011) is implemented as above, with a `WIDTH`-cycle iterative shift-add multiplier.
- **Undefined:**
  - 0011 is an illegal code: result 0, Z=1, one-cycle latency.
  - No MUL state and no multiplier logic.
  - `busy` is tied to 0.

## Structure
- **Package `function_unit_pkg`:**
  - `fs_e` enum holding all function encodings.
  - Flag bit-index constants `FLAG_Z`=3, `FLAG_C`=2, `FLAG_N`=1, `FLAG_V`=0.
  - FSM state enum.
- **Sub-module `mul_iter`:**
  - Parametrised by `WIDTH`.
  - Signals: start/operands in, done/product out.
  - Instantiated only under `FUNCTION_UNIT_MUL_EN`.
- **Top level:** the combinational ALU/shift/compare datapath, the FSM, and the output register live in the top module.

## Test plan
- **ADD overflow:** ADD a=0x7FFFFFFF, b=0x00000001, `out_ready`=1 → result 0x80000000, flags Z0 C0 N1 V1, `out_valid` one edge after accept.
- **SUB zero:** SUB a=5, b=5 → result 0, flags Z1 C1 N0 V0. SUB a=0, b=1 → 0xFFFFFFFF, flags Z0 C0 N1 V0.
- **Compare:** a=0xFFFFFFFF, b=1: SLT → 1, SLTU → 0.
- **Shift:** SRA a=0x80000000, b=0x00000024 → 0xF8000000 (amount 4). SRL with the same operands → 0x08000000.
- **MUL, macro defined:** MUL a=0x00010000, b=0x00010001 → result 0x00010000. `in_ready`=0 and `busy`=1 for 32 edges; `out_valid` rises after edge t+32.
- **MUL, macro undefined:** the same MUL → result 0, Z=1, after 1 edge.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles after an ADD result → `result` stable and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 on the same edge → old result transferred and the new result loaded, `out_valid` stays 1.
- **Reset mid-MUL:** assert `rst` 10 cycles into a MUL → next cycle `busy`=0, `out_valid`=0, and `in_ready`=1 once `rst` is released.
